// File: rtl/entrega_troco.sv
// Change dispenser controller: runs the product motor, waits for the drop sensor, then ejects change greedily.
// Optional ESPERA timeout (sale converted to full refund) enabled by defining SENSOR_TIMEOUT_EN.
module entrega_troco #(
    parameter int MOTOR_CYCLES   = 4,
    parameter int COIN_PULSE     = 2,
    parameter int SENSOR_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       LP,
    input  logic       DM,
    input  logic [3:0] vTotal,
    input  logic [2:0] vProduto,
    input  logic       sensor,
    output logic       motor,
    output logic       ejeta2,
    output logic       ejeta1,
    output logic       ocupado,
    output logic       fim,
    output logic       erro
);

    localparam int CNT_A   = (MOTOR_CYCLES > COIN_PULSE) ? MOTOR_CYCLES : COIN_PULSE;
    localparam int CNT_MAX = (CNT_A > SENSOR_TIMEOUT) ? CNT_A : SENSOR_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LIBERA,
        ESPERA,
        PULSO,
        INTERVALO,
        FIM
    } state_t;

    state_t        state, state_n;
    logic [3:0]    restante, restante_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          erro_q, erro_n;
    logic          curto;

`ifdef SENSOR_TIMEOUT_EN
    logic [3:0]    vtotal_lat, vtotal_n;
`endif

    assign curto = vTotal < {1'b0, vProduto};

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            restante   <= '0;
            cnt        <= '0;
            erro_q     <= 1'b0;
`ifdef SENSOR_TIMEOUT_EN
            vtotal_lat <= '0;
`endif
        end else begin
            state      <= state_n;
            restante   <= restante_n;
            cnt        <= cnt_n;
            erro_q     <= erro_n;
`ifdef SENSOR_TIMEOUT_EN
            vtotal_lat <= vtotal_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        restante_n = restante;
        cnt_n      = cnt;
        erro_n     = 1'b0;
`ifdef SENSOR_TIMEOUT_EN
        vtotal_n   = vtotal_lat;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                // Refund path covers DM and sales the inserted value cannot pay for; DM has priority.
                if (DM || (LP && curto)) begin
                    restante_n = vTotal;
                    erro_n     = ~DM;
                    state_n    = (vTotal == '0) ? FIM : PULSO;
                end else if (LP) begin
                    restante_n = vTotal - {1'b0, vProduto};
                    state_n    = LIBERA;
`ifdef SENSOR_TIMEOUT_EN
                    vtotal_n   = vTotal;
`endif
                end
            end
            LIBERA: begin
                if (cnt == CW'(MOTOR_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = ESPERA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ESPERA: begin
                if (sensor) begin
                    cnt_n   = '0;
                    state_n = (restante != '0) ? PULSO : FIM;
                end
`ifdef SENSOR_TIMEOUT_EN
                else if (cnt == CW'(SENSOR_TIMEOUT - 1)) begin
                    cnt_n      = '0;
                    erro_n     = 1'b1;
                    restante_n = vtotal_lat;
                    state_n    = (vtotal_lat != '0) ? PULSO : FIM;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
`endif
            end
            PULSO: begin
                if (cnt == CW'(COIN_PULSE - 1)) begin
                    cnt_n      = '0;
                    restante_n = (restante >= 4'd2) ? restante - 4'd2 : restante - 4'd1;
                    state_n    = INTERVALO;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            INTERVALO: state_n = (restante != '0) ? PULSO : FIM;
            FIM:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign motor   = (state == LIBERA);
    assign ejeta2  = (state == PULSO) && (restante >= 4'd2);
    assign ejeta1  = (state == PULSO) && (restante <  4'd2);
    assign ocupado = (state != IDLE);
    assign fim     = (state == FIM);
    assign erro    = erro_q;

endmodule

// File: tb/tb_entrega_troco.sv
// Bench for entrega_troco: directed vector table, reset corner cases and random transactions
// checked cycle by cycle against an expected output trace built from the coin/motor rules.
module tb_entrega_troco;

    localparam int MC = 4;
    localparam int CP = 2;
    localparam int TO = 10;

    logic       CLK = 1'b0;
    logic       rst, LP, DM, sensor;
    logic [3:0] vTotal;
    logic [2:0] vProduto;
    logic       motor, ejeta2, ejeta1, ocupado, fim, erro;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit lp;
        bit dm;
        int vt;
        int vp;
        int d;
        bit to;
        int mot;
        int n2;
        int n1;
        int er;
    } vec_t;

    entrega_troco #(
        .MOTOR_CYCLES  (MC),
        .COIN_PULSE    (CP),
        .SENSOR_TIMEOUT(TO)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .LP      (LP),
        .DM      (DM),
        .vTotal  (vTotal),
        .vProduto(vProduto),
        .sensor  (sensor),
        .motor   (motor),
        .ejeta2  (ejeta2),
        .ejeta1  (ejeta1),
        .ocupado (ocupado),
        .fim     (fim),
        .erro    (erro)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] outs();
        return {motor, ejeta2, ejeta1, ocupado, fim, erro};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Bit order of trace entries: {motor, ejeta2, ejeta1, ocupado, fim, erro}.
    task automatic run_txn(input bit lp, input bit dm, input int vt, input int vp, input int d,
                           input bit to, input int id,
                           output int mot, output int n2, output int n1, output int er, output int nf);
        logic [5:0] exp_q[$];
        logic [5:0] o, prev;
        int  r, sk, ncoin;
        bit  refund, e, first;
        exp_q.push_back(6'b000000);
        refund = dm || (lp && vt < vp);
        e      = lp && !dm && (vt < vp);
        sk     = -1;
        r      = vt;
        if (!refund) begin
            r = vt - vp;
            repeat (MC) exp_q.push_back(6'b100100);
            if (to) begin
                repeat (TO) exp_q.push_back(6'b000100);
                r = vt;
                e = 1'b1;
            end else begin
                sk = exp_q.size() + d;
                repeat (d + 1) exp_q.push_back(6'b000100);
            end
        end
        first = 1'b1;
        ncoin = r / 2 + r % 2;
        for (int i = 0; i < ncoin; i++) begin
            for (int j = 0; j < CP; j++) begin
                exp_q.push_back({1'b0, i < r / 2, i >= r / 2, 1'b1, 1'b0, e && first});
                first = 1'b0;
            end
            exp_q.push_back(6'b000100);
        end
        exp_q.push_back({5'b00011, e && first});

        mot = 0; n2 = 0; n1 = 0; er = 0; nf = 0;
        prev = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) begin
                LP = lp; DM = dm; vTotal = 4'(vt); vProduto = 3'(vp);
            end else if (exp_q[k][2]) begin
                LP = 1'($urandom); DM = 1'($urandom);
                vTotal = 4'($urandom); vProduto = 3'($urandom);
            end else begin
                LP = 1'b0; DM = 1'b0;
            end
            sensor = (k == sk);
            @(negedge CLK);
            o = outs();
            checks++;
            if (o !== exp_q[k]) begin
                failures++;
                $display("FAIL trace txn=%0d cyc=%0d got=%b want=%b", id, k, o, exp_q[k]);
            end
            check("strobe_excl", int'((o[4] && o[3]) || (o[5] && (o[4] || o[3]))), 0);
            mot += int'(o[5]);
            n2  += int'(o[4] && !prev[4]);
            n1  += int'(o[3] && !prev[3]);
            er  += int'(o[0]);
            nf  += int'(o[1]);
            prev = o;
            @(posedge CLK);
            #1;
        end
        LP = 1'b0; DM = 1'b0; sensor = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        int   mot, n2, n1, er, nf, kind;
        bit   seen, bad;

        tbl[0] = '{1, 0,  7, 4, 2, 0, 4, 1, 1, 0};
        tbl[1] = '{0, 1,  5, 0, 0, 0, 0, 2, 1, 0};
        tbl[2] = '{1, 0,  3, 3, 1, 0, 4, 0, 0, 0};
        tbl[3] = '{1, 1,  2, 5, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 0,  3, 6, 0, 0, 0, 1, 1, 1};
        tbl[5] = '{0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 0, 15, 0, 0, 0, 4, 7, 1, 0};
`ifdef SENSOR_TIMEOUT_EN
        tbl[8] = '{1, 0,  4, 2, 0, 1, 4, 2, 0, 1};
`else
        tbl[8] = '{1, 0,  4, 2, 20, 0, 4, 1, 0, 0};
`endif

        rst = 1'b0; LP = 1'b0; DM = 1'b0; sensor = 1'b0;
        vTotal = '0; vProduto = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outs", int'(outs()), 0);
        @(posedge CLK);
        #1 rst = 1'b1;
        @(negedge CLK);
        check("idle_outs", int'(outs()), 0);
        @(posedge CLK);
        #1;

        for (int t = 0; t < 9; t++) begin
            run_txn(tbl[t].lp, tbl[t].dm, tbl[t].vt, tbl[t].vp, tbl[t].d, tbl[t].to, t,
                    mot, n2, n1, er, nf);
            check($sformatf("vec%0d_motor", t), mot, tbl[t].mot);
            check($sformatf("vec%0d_ej2", t), n2, tbl[t].n2);
            check($sformatf("vec%0d_ej1", t), n1, tbl[t].n1);
            check($sformatf("vec%0d_erro", t), er, tbl[t].er);
            check($sformatf("vec%0d_fim", t), nf, 1);
        end

        // Reset asserted during the first 2-unit strobe of a 5-unit change.
        LP = 1'b1; vTotal = 4'd6; vProduto = 3'd1; sensor = 1'b1;
        @(posedge CLK);
        #1 LP = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (ejeta2) seen = 1'b1;
        end
        check("rst_wait_ej2", int'(seen), 1);
        #2 rst = 1'b0;
        #1 check("rst_async_outs", int'(outs()), 0);
        sensor = 1'b0;
        @(posedge CLK);
        #1 rst = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (outs() != 6'b0) bad = 1'b1;
        end
        check("rst_quiet", int'(bad), 0);
        @(posedge CLK);
        #1;

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            run_txn(kind != 0, kind == 0 || kind == 2, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 100 + t,
                    mot, n2, n1, er, nf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
